// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared decode definitions for the operand-fetch slice.
//               Holds the opcode values, the instruction field layout
//               helpers (opcode, rd, rs1, rs2, imm packed MSB first) and
//               the "does this opcode write rd" rule.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int OPCODE_SIZE = 7;

    localparam logic [OPCODE_SIZE-1:0] OP_NOP    = 7'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_ALU    = 7'd1;
    localparam logic [OPCODE_SIZE-1:0] OP_ALUI   = 7'd2;
    localparam logic [OPCODE_SIZE-1:0] OP_LOAD   = 7'd3;
    localparam logic [OPCODE_SIZE-1:0] OP_STORE  = 7'd4;
    localparam logic [OPCODE_SIZE-1:0] OP_BRANCH = 7'd5;

    // Field LSB positions; the immediate occupies every bit below rs2.
    function automatic int rd_lsb(input int instr_size, input int addr_size);
        return instr_size - OPCODE_SIZE - addr_size;
    endfunction

    function automatic int rs1_lsb(input int instr_size, input int addr_size);
        return instr_size - OPCODE_SIZE - 2 * addr_size;
    endfunction

    function automatic int rs2_lsb(input int instr_size, input int addr_size);
        return instr_size - OPCODE_SIZE - 3 * addr_size;
    endfunction

    function automatic int imm_size(input int instr_size, input int addr_size);
        return instr_size - OPCODE_SIZE - 3 * addr_size;
    endfunction

    // Opcodes that produce a register result (rd != 0 is checked by the user).
    function automatic logic opcode_writes_rd(input logic [OPCODE_SIZE-1:0] op);
        return !((op == OP_NOP) || (op == OP_STORE) || (op == OP_BRANCH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_scoreboard
// Description : Per-register busy vector tracking in-flight writers.
//               Ports:
//                 clk, reset          - clock, async active-high reset
//                 set_valid/set_addr  - mark a destination busy (issue)
//                 clr_valid/clr_addr  - mark a register free (writeback)
//                 src1/src2/dst_addr  - query addresses
//                 src1/src2/dst_busy  - busy, with same-cycle clear bypass
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_scoreboard #(
    parameter int ADDRESS_SIZE = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_valid,
    input  logic [ADDRESS_SIZE-1:0] set_addr,
    input  logic                    clr_valid,
    input  logic [ADDRESS_SIZE-1:0] clr_addr,
    input  logic [ADDRESS_SIZE-1:0] src1_addr,
    input  logic [ADDRESS_SIZE-1:0] src2_addr,
    input  logic [ADDRESS_SIZE-1:0] dst_addr,
    output logic                    src1_busy,
    output logic                    src2_busy,
    output logic                    dst_busy
);

    localparam int NUM_REGS = 2 ** ADDRESS_SIZE;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    // Clear first, then set: an issue to the register being written back
    // in the same cycle leaves it busy for the new writer.
    always_comb begin
        w_busy_next = r_busy;
        if (clr_valid) begin
            w_busy_next[clr_addr] = 1'b0;
        end
        if (set_valid) begin
            w_busy_next[set_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // A writeback landing this cycle already resolves the hazard.
    assign src1_busy = r_busy[src1_addr] && !(clr_valid && (clr_addr == src1_addr));
    assign src2_busy = r_busy[src2_addr] && !(clr_valid && (clr_addr == src2_addr));
    assign dst_busy  = r_busy[dst_addr]  && !(clr_valid && (clr_addr == dst_addr));

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Decode / operand-fetch stage in front of register_bank.
//               Splits the instruction, drives the bank read addresses,
//               forwards same-cycle writeback data and registers the
//               result for execute. A scoreboard stalls RAW/WAW hazards.
//               Ports:
//                 clk, reset                 - clock, async active-high reset
//                 in_valid/in_ready/in_instr - instruction handshake
//                 rf_addr1/2, rf_data1/2     - register_bank read ports
//                 wb_valid/wb_addr/wb_data   - writeback (shared with bank)
//                 out_valid/out_ready        - execute handshake
//                 out_opcode/rd/op1/op2/imm  - registered decoded payload
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int ADDRESS_SIZE  = 5,
    parameter int REGISTER_SIZE = 8,
    parameter int INSTR_SIZE    = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [INSTR_SIZE-1:0]                   in_instr,
    output logic [ADDRESS_SIZE-1:0]                 rf_addr1,
    output logic [ADDRESS_SIZE-1:0]                 rf_addr2,
    input  logic [REGISTER_SIZE-1:0]                rf_data1,
    input  logic [REGISTER_SIZE-1:0]                rf_data2,
    input  logic                                    wb_valid,
    input  logic [ADDRESS_SIZE-1:0]                 wb_addr,
    input  logic [REGISTER_SIZE-1:0]                wb_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [6:0]                              out_opcode,
    output logic [ADDRESS_SIZE-1:0]                 out_rd,
    output logic [REGISTER_SIZE-1:0]                out_op1,
    output logic [REGISTER_SIZE-1:0]                out_op2,
    output logic [INSTR_SIZE-7-3*ADDRESS_SIZE-1:0]  out_imm
);

    localparam int RD_LSB   = rd_lsb(INSTR_SIZE, ADDRESS_SIZE);
    localparam int RS1_LSB  = rs1_lsb(INSTR_SIZE, ADDRESS_SIZE);
    localparam int RS2_LSB  = rs2_lsb(INSTR_SIZE, ADDRESS_SIZE);
    localparam int IMM_SIZE = imm_size(INSTR_SIZE, ADDRESS_SIZE);

    logic [OPCODE_SIZE-1:0]   w_opcode;
    logic [ADDRESS_SIZE-1:0]  w_rd;
    logic [ADDRESS_SIZE-1:0]  w_rs1;
    logic [ADDRESS_SIZE-1:0]  w_rs2;
    logic [IMM_SIZE-1:0]      w_imm;
    logic                     w_writes_rd;
    logic                     w_src1_busy;
    logic                     w_src2_busy;
    logic                     w_dst_busy;
    logic                     w_hazard;
    logic                     w_fire;
    logic [REGISTER_SIZE-1:0] w_op1;
    logic [REGISTER_SIZE-1:0] w_op2;

    logic                     r_out_valid;
    logic [OPCODE_SIZE-1:0]   r_opcode;
    logic [ADDRESS_SIZE-1:0]  r_rd;
    logic [REGISTER_SIZE-1:0] r_op1;
    logic [REGISTER_SIZE-1:0] r_op2;
    logic [IMM_SIZE-1:0]      r_imm;

    // Field split, MSB first: opcode, rd, rs1, rs2, imm.
    assign w_opcode = in_instr[INSTR_SIZE-1 -: OPCODE_SIZE];
    assign w_rd     = in_instr[RD_LSB  +: ADDRESS_SIZE];
    assign w_rs1    = in_instr[RS1_LSB +: ADDRESS_SIZE];
    assign w_rs2    = in_instr[RS2_LSB +: ADDRESS_SIZE];
    assign w_imm    = in_instr[IMM_SIZE-1:0];

    // Bank reads are combinational and follow in_instr even when idle.
    assign rf_addr1 = w_rs1;
    assign rf_addr2 = w_rs2;

    assign w_writes_rd = opcode_writes_rd(w_opcode) && (w_rd != '0);

    operand_fetch_scoreboard #(
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (w_fire && w_writes_rd),
        .set_addr  (w_rd),
        .clr_valid (wb_valid),
        .clr_addr  (wb_addr),
        .src1_addr (w_rs1),
        .src2_addr (w_rs2),
        .dst_addr  (w_rd),
        .src1_busy (w_src1_busy),
        .src2_busy (w_src2_busy),
        .dst_busy  (w_dst_busy)
    );

    assign w_hazard = w_src1_busy || w_src2_busy || (w_writes_rd && w_dst_busy);
    assign in_ready = !w_hazard && (!r_out_valid || out_ready);
    assign w_fire   = in_valid && in_ready;

    // The bank returns the pre-write value during a writeback cycle, so the
    // writeback data is bypassed here (register 0 included).
    assign w_op1 = (wb_valid && (wb_addr == w_rs1)) ? wb_data : rf_data1;
    assign w_op2 = (wb_valid && (wb_addr == w_rs2)) ? wb_data : rf_data2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_imm       <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_opcode    <= w_opcode;
            r_rd        <= w_rd;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_imm       <= w_imm;
        end else if (out_ready) begin
            // Payload is left as-is; only the valid flag drops.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_opcode = r_opcode;
    assign out_rd     = r_rd;
    assign out_op1    = r_op1;
    assign out_op2    = r_op2;
    assign out_imm    = r_imm;

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage directly upstream of register_bank.
- Splits each incoming instruction into fields and drives the bank's two read addresses.
- Captures the returned operands, forwarding same-cycle writeback data, into a single output pipeline register for execute.
- A per-register scoreboard stalls on RAW/WAW hazards against in-flight writers.

Parameters:
- ADDRESS_SIZE, 5, register address width; must match register_bank ADDRESS_SIZE.
- REGISTER_SIZE, 8, data width; must match register_bank REGISTER_SIZE.
- INSTR_SIZE, 32, instruction width; must be at least 7+3*ADDRESS_SIZE+1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents in_instr.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  INSTR_SIZE  fields, MSB first: opcode[7], rd, rs1, rs2, imm (remaining low bits).
- rf_addr1  out  ADDRESS_SIZE  to register_bank addr_out1; equals in_instr.rs1.
- rf_addr2  out  ADDRESS_SIZE  to register_bank addr_out2; equals in_instr.rs2.
- rf_data1  in  REGISTER_SIZE  from register_bank data_out1.
- rf_data2  in  REGISTER_SIZE  from register_bank data_out2.
- wb_valid  in  1  writeback this cycle (same signal drives bank write).
- wb_addr  in  ADDRESS_SIZE  writeback register (bank addr_in).
- wb_data  in  REGISTER_SIZE  writeback value (bank data_in).
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  execute accepts output this cycle.
- out_opcode  out  7  opcode.
- out_rd  out  ADDRESS_SIZE  destination register.
- out_op1  out  REGISTER_SIZE  resolved rs1 operand.
- out_op2  out  REGISTER_SIZE  resolved rs2 operand.
- out_imm  out  INSTR_SIZE-7-3*ADDRESS_SIZE  immediate field, raw.

Behaviour:
- Register_bank reads are combinational. rf_addr1/2 follow in_instr combinationally, regardless of in_valid.
- writes_rd = opcode not in {OP_NOP, OP_STORE, OP_BRANCH}, and rd != 0.
- Register 0 is never marked busy.
- Scoreboard: busy[2^ADDRESS_SIZE] bits.
- clear_hit(r) = wb_valid and wb_addr==r.
- src_busy(r) = busy[r] and not clear_hit(r). Same-cycle writeback resolves the hazard.
- hazard = src_busy(rs1) or src_busy(rs2) or (writes_rd and src_busy(rd)).
- in_ready = !hazard and (!out_valid or out_ready). Combinational; no dependency on in_valid.
- fire = in_valid and in_ready.
- Operand resolution: op1 = clear_hit(rs1) ? wb_data : rf_data1; op2 likewise. Forwarding applies to register 0 too.
- On fire, output register loads opcode, rd, op1, op2, imm; out_valid<=1. Latency in_valid to out_valid is one cycle.
- If out_valid and out_ready and not fire: out_valid<=0. Payload holds its value.
- If out_valid and not out_ready: all output fields are stable.
- Busy update per cycle: clear wb_addr if wb_valid, then set rd if fire and writes_rd. If both hit the same register, set wins.
- Throughput: one instruction per cycle with no hazards and out_ready high.
- Reset (async, any time, including mid-stall):
  - busy all 0, out_valid 0, out_opcode 0, out_rd 0, out_op1 0, out_op2 0, out_imm 0.
  - In-flight writebacks after reset are not tracked.
- wb_addr==0 with wb_valid: accepted, no scoreboard effect.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants OP_NOP=0, OP_ALU=1, OP_ALUI=2, OP_LOAD=3, OP_STORE=4, OP_BRANCH=5.
  - Field-offset localparams derived from INSTR_SIZE/ADDRESS_SIZE.
- One sub-module, scoreboard: busy vector, set/clear ports, two source query ports plus one dest query port with clear-bypass.

Test Plan:
- Reset mid-stall: busy[3]=1 with ALU rs1=3 stalled, assert reset -> out_valid=0 and in_ready=1 immediately (async); after release the same instruction fires next edge.
- Back-to-back independent: ALU rd=1,rs1=2,rs2=3 then ALU rd=4,rs1=5,rs2=6, bank r2=0x11 r3=0x22, out_ready=1 -> out_op1/op2 = 0x11/0x22 one cycle after first accept; in_ready stays 1.
- RAW stall: ALU rd=5 issued; next ALU rs1=5 -> in_ready=0 until wb_valid,wb_addr=5,wb_data=0xA5 -> fires that cycle with out_op1=0xA5 (forwarded, not stale bank value).
- WAW plus set-wins: LOAD rd=7 busy; second LOAD rd=7 stalls; cycle with wb_addr=7 and fire -> busy[7] remains 1 afterwards.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0; out_* unchanged for 4 cycles; out_ready=1 -> next queued instruction loads same edge.
- r0/STORE: STORE rd=0,rs1=0 and ALU rd=0 -> never stall; busy[0] stays 0; wb to r0 ignored by scoreboard.
